// File: rtl/stdp_synapse.sv
// stdp_synapse: single plastic synapse with pair-based STDP learning.
// Presynaptic and postsynaptic spikes each reload a decaying trace.
// The weight is potentiated when a post spike lands while the pre trace
// is live, and depressed when a pre spike lands while the post trace is
// live. A pre spike emits the current weight as a one-cycle activation.
module stdp_synapse #(
    parameter logic [7:0] W_INIT    = 8'd64,
    parameter logic [3:0] TRACE_MAX = 4'd15,
    parameter logic [7:0] A_PLUS    = 8'd8,
    parameter logic [7:0] A_MINUS   = 8'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pre_spike,
    input  logic       post_spike,
    input  logic       learn,
    output logic [7:0] activation
);

    logic [7:0]        r_weight;
    logic [3:0]        r_pre_trace;
    logic [3:0]        r_post_trace;
    logic [7:0]        r_activation;

    logic              w_pot;
    logic              w_dep;
    logic signed [9:0] w_sum;
    logic [7:0]        w_weight_next;
    logic [3:0]        w_pre_trace_next;
    logic [3:0]        w_post_trace_next;

    // Learning conditions use the traces as registered before this edge
    assign w_pot = learn & post_spike & (r_pre_trace  != '0);
    assign w_dep = learn & pre_spike  & (r_post_trace != '0);

    // Net weight change at 10-bit signed width, then clamp to 0..255
    always_comb begin
        w_sum = $signed({2'b00, r_weight});
        if (w_pot) begin
            w_sum = w_sum + $signed({2'b00, A_PLUS});
        end
        if (w_dep) begin
            w_sum = w_sum - $signed({2'b00, A_MINUS});
        end
        if (w_sum < 10'sd0) begin
            w_weight_next = '0;
        end else if (w_sum > 10'sd255) begin
            w_weight_next = '1;
        end else begin
            w_weight_next = w_sum[7:0];
        end
    end

    // Trace reload on a spike, otherwise decay toward zero without wrapping
    always_comb begin
        if (pre_spike) begin
            w_pre_trace_next = TRACE_MAX;
        end else if (r_pre_trace != '0) begin
            w_pre_trace_next = r_pre_trace - 4'd1;
        end else begin
            w_pre_trace_next = '0;
        end

        if (post_spike) begin
            w_post_trace_next = TRACE_MAX;
        end else if (r_post_trace != '0) begin
            w_post_trace_next = r_post_trace - 4'd1;
        end else begin
            w_post_trace_next = '0;
        end
    end

    // State update: reset dominates; traces update regardless of learn
    always_ff @(posedge clk) begin
        if (reset) begin
            r_weight     <= W_INIT;
            r_pre_trace  <= '0;
            r_post_trace <= '0;
            r_activation <= '0;
        end else begin
            r_pre_trace  <= w_pre_trace_next;
            r_post_trace <= w_post_trace_next;
            r_activation <= pre_spike ? r_weight : 8'd0;
            if (learn) begin
                r_weight <= w_weight_next;
            end
        end
    end

    assign activation = r_activation;

endmodule
